// File: rtl/pin_lock_pkg.sv
// Shared state encodings and width helper for the keypad lock.
package pin_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2,
    ST_PROGRAM  = 2'd3
  } state_e;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pin_lock_timer.sv
// Loadable down-counter that parks at zero; expired flags the zero count.
module pin_lock_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pin_lock.sv
// Keypad lock: fixed-length code entry, retry limit with timed lockout,
// and a run-time programmable code.
module pin_lock
  import pin_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned PIN_LEN        = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter logic [DIGIT_W*PIN_LEN-1:0] DEFAULT_PIN = 16'hC0DE
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DIGIT_W-1:0]                 din,
  input  logic                               din_valid,
  input  logic                               relock,
  input  logic                               prog_en,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic                               programming,
  output logic [clog2(MAX_TRIES+1)-1:0]      fail_count,
  output logic                               attempt_ok,
  output logic                               attempt_bad
);

  localparam int unsigned CODE_W = DIGIT_W * PIN_LEN;
  localparam int unsigned FC_W   = clog2(MAX_TRIES + 1);
  localparam int unsigned IDX_W  = (PIN_LEN > 1) ? clog2(PIN_LEN) : 1;
  localparam int unsigned TMR_W  = (LOCKOUT_CYCLES > 1) ? clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PIN_LEN - 1);
  localparam logic [FC_W-1:0]  FAIL_LIMIT = FC_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FC_W-1:0]     fail_q, fail_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   sr_q, sr_d;
  logic                ok_q, ok_d;
  logic                bad_q, bad_d;
  logic                unlocked_q, locked_out_q, programming_q;

  logic [CODE_W-1:0]   shifted;
  logic [FC_W-1:0]     fail_inc;
  logic                tmr_load;
  logic                tmr_expired;

  // Newest digit enters at the LSB end; the first digit ends up most significant.
  assign shifted  = CODE_W'({sr_q, din});
  assign fail_inc = fail_q + FC_W'(1);

  pin_lock_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TMR_LOAD),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    code_d   = code_q;
    sr_d     = sr_q;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
    tmr_load = 1'b0;

    case (state_q)
      ST_ENTRY: begin
        if (din_valid) begin
          sr_d = shifted;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (shifted == code_q) begin
              state_d = ST_UNLOCKED;
              fail_d  = '0;
              ok_d    = 1'b1;
            end else begin
              bad_d  = 1'b1;
              fail_d = fail_inc;
              if (fail_inc == FAIL_LIMIT) begin
                state_d  = ST_LOCKOUT;
                tmr_load = 1'b1;
              end
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
          idx_d   = '0;
        end
      end

      ST_UNLOCKED: begin
        if (relock) begin
          state_d = ST_ENTRY;
        end else if (prog_en) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
        end
      end

      ST_PROGRAM: begin
        // An abort leaves the stored code alone and starts the next entry fresh.
        if (relock) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else if (din_valid) begin
          sr_d = shifted;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            code_d  = shifted;
            state_d = ST_UNLOCKED;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ENTRY;
      idx_q         <= '0;
      fail_q        <= '0;
      code_q        <= DEFAULT_PIN;
      sr_q          <= '0;
      ok_q          <= 1'b0;
      bad_q         <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      programming_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fail_q        <= fail_d;
      code_q        <= code_d;
      sr_q          <= sr_d;
      ok_q          <= ok_d;
      bad_q         <= bad_d;
      unlocked_q    <= (state_d == ST_UNLOCKED);
      locked_out_q  <= (state_d == ST_LOCKOUT);
      programming_q <= (state_d == ST_PROGRAM);
    end
  end

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign programming = programming_q;
  assign fail_count  = fail_q;
  assign attempt_ok  = ok_q;
  assign attempt_bad = bad_q;

endmodule

// File: tb/tb_pin_lock.sv
// Bench for pin_lock: default instance plus an 8-bit/6-digit/1-try instance.
module tb_pin_lock;

  localparam logic [15:0] A_PIN = 16'hC0DE;
  localparam logic [47:0] B_PIN = 48'hA53C00FF12E7;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [3:0] a_din = '0;
  logic       a_valid = 1'b0, a_relock = 1'b0, a_prog = 1'b0;
  logic       a_unl, a_lo, a_pr, a_ok, a_bad;
  logic [1:0] a_fc;

  logic [7:0] b_din = '0;
  logic       b_valid = 1'b0, b_relock = 1'b0, b_prog = 1'b0;
  logic       b_unl, b_lo, b_pr, b_ok, b_bad;
  logic [0:0] b_fc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the code currently accepted and consecutive failures.
  logic [15:0] m_code;
  int          m_fails;

  always #5 clk = ~clk;

  pin_lock dut_a (
    .clk(clk), .reset(reset), .din(a_din), .din_valid(a_valid),
    .relock(a_relock), .prog_en(a_prog), .unlocked(a_unl), .locked_out(a_lo),
    .programming(a_pr), .fail_count(a_fc), .attempt_ok(a_ok), .attempt_bad(a_bad)
  );

  pin_lock #(
    .DIGIT_W(8), .PIN_LEN(6), .MAX_TRIES(1), .LOCKOUT_CYCLES(3), .DEFAULT_PIN(B_PIN)
  ) dut_b (
    .clk(clk), .reset(reset), .din(b_din), .din_valid(b_valid),
    .relock(b_relock), .prog_en(b_prog), .unlocked(b_unl), .locked_out(b_lo),
    .programming(b_pr), .fail_count(b_fc), .attempt_ok(b_ok), .attempt_bad(b_bad)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    a_valid = 0; a_relock = 0; a_prog = 0;
    b_valid = 0; b_relock = 0; b_prog = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    m_code  = A_PIN;
    m_fails = 0;
  endtask

  // Drive four digits on consecutive cycles; early flags any result before the last one.
  task automatic a_enter(input logic [15:0] code, output bit early);
    early = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0 && (a_ok || a_bad || a_unl)) early = 1;
      a_din   = code[15-4*i -: 4];
      a_valid = 1;
    end
    @(negedge clk);
    a_valid = 0;
  endtask

  task automatic b_enter(input logic [47:0] code);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_din   = code[47-8*i -: 8];
      b_valid = 1;
    end
    @(negedge clk);
    b_valid = 0;
  endtask

  task automatic a_relock_pulse();
    @(negedge clk); a_relock = 1;
    @(negedge clk); a_relock = 0;
  endtask

  // Count cycles with locked_out high while spraying random digits at the lock.
  task automatic a_wait_lockout(output int cycles);
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (!a_lo) break;
      cycles++;
      a_din   = 4'($urandom);
      a_valid = 1;
    end
    a_valid = 0;
  endtask

  task automatic b_wait_lockout(output int cycles);
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (!b_lo) break;
      cycles++;
      b_din   = 8'($urandom);
      b_valid = 1;
    end
    b_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({a_unl, a_lo, a_pr, a_ok, a_bad} !== 5'b0) begin
      n_fail++; $display("FAIL reset_a_status: got %b exp 00000", {a_unl, a_lo, a_pr, a_ok, a_bad});
    end
    n_tests++;
    if (a_fc !== 2'd0) begin
      n_fail++; $display("FAIL reset_a_fail_count: got %0d exp 0", a_fc);
    end
    n_tests++;
    if ({b_unl, b_lo, b_pr, b_ok, b_bad, b_fc} !== 6'b0) begin
      n_fail++; $display("FAIL reset_b_status: got %b exp 000000", {b_unl, b_lo, b_pr, b_ok, b_bad, b_fc});
    end
  endtask

  task automatic test_unlock();
    bit early;
    do_reset();
    a_enter(A_PIN, early);
    n_tests++;
    if ({early, a_unl, a_ok, a_bad, a_fc} !== 6'b0_1_1_0_00) begin
      n_fail++; $display("FAIL unlock_default: got early=%b unl=%b ok=%b bad=%b fc=%0d exp 0 1 1 0 0",
                         early, a_unl, a_ok, a_bad, a_fc);
    end
    @(negedge clk);
    n_tests++;
    if ({a_unl, a_ok} !== 2'b10) begin
      n_fail++; $display("FAIL unlock_ok_single_pulse: got unl=%b ok=%b exp 1 0", a_unl, a_ok);
    end
  endtask

  task automatic test_no_backdoor();
    bit early;
    do_reset();
    a_enter(16'hF00F, early);
    n_tests++;
    if ({early, a_unl, a_ok, a_bad, a_fc} !== 6'b0_0_0_1_01) begin
      n_fail++; $display("FAIL wrong_f00f: got early=%b unl=%b ok=%b bad=%b fc=%0d exp 0 0 0 1 1",
                         early, a_unl, a_ok, a_bad, a_fc);
    end
    @(negedge clk);
    n_tests++;
    if (a_bad !== 1'b0) begin
      n_fail++; $display("FAIL bad_single_pulse: got %b exp 0", a_bad);
    end
  endtask

  task automatic test_lockout();
    bit early;
    int cyc;
    do_reset();
    for (int t = 1; t <= 3; t++) begin
      a_enter(16'h1234, early);
      n_tests++;
      if ({a_bad, a_lo, a_fc} !== {1'b1, (t == 3), 2'(t)}) begin
        n_fail++; $display("FAIL lockout_try%0d: got bad=%b lo=%b fc=%0d exp 1 %0d %0d",
                           t, a_bad, a_lo, a_fc, (t == 3), t);
      end
    end
    a_wait_lockout(cyc);
    n_tests++;
    if (cyc !== 16) begin
      n_fail++; $display("FAIL lockout_duration: got %0d cycles exp 16", cyc);
    end
    n_tests++;
    if ({a_lo, a_fc} !== 3'b0) begin
      n_fail++; $display("FAIL lockout_exit: got lo=%b fc=%0d exp 0 0", a_lo, a_fc);
    end
    a_enter(A_PIN, early);
    n_tests++;
    if ({a_unl, a_ok} !== 2'b11) begin
      n_fail++; $display("FAIL unlock_after_lockout: got unl=%b ok=%b exp 1 1", a_unl, a_ok);
    end
  endtask

  task automatic test_random_attempts();
    bit early;
    int cyc;
    logic [15:0] code;
    bit exp_ok, exp_lock;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      code = ($urandom_range(0, 2) == 0) ? m_code : 16'($urandom);
      exp_ok = (code == m_code);
      if (exp_ok) m_fails = 0;
      else        m_fails = m_fails + 1;
      exp_lock = (m_fails == 3);
      a_enter(code, early);
      n_tests++;
      if ({early, a_ok, a_bad, a_unl, a_lo, a_fc} !== {1'b0, exp_ok, !exp_ok, exp_ok, exp_lock, 2'(m_fails)}) begin
        n_fail++; $display("FAIL random_attempt%0d code=%h: got early=%b ok=%b bad=%b unl=%b lo=%b fc=%0d exp 0 %b %b %b %b %0d",
                           k, code, early, a_ok, a_bad, a_unl, a_lo, a_fc, exp_ok, !exp_ok, exp_ok, exp_lock, m_fails);
      end
      if (exp_ok) begin
        a_relock_pulse();
        n_tests++;
        if (a_unl !== 1'b0) begin
          n_fail++; $display("FAIL random_relock%0d: got unl=%b exp 0", k, a_unl);
        end
      end
      if (exp_lock) begin
        a_wait_lockout(cyc);
        m_fails = 0;
        n_tests++;
        if (cyc !== 16) begin
          n_fail++; $display("FAIL random_lockout%0d: got %0d cycles exp 16", k, cyc);
        end
      end
    end
  endtask

  task automatic test_program();
    bit early;
    logic [15:0] new_code;
    do_reset();
    a_enter(m_code, early);
    @(negedge clk); a_prog = 1;
    @(negedge clk); a_prog = 0;
    n_tests++;
    if ({a_pr, a_unl} !== 2'b10) begin
      n_fail++; $display("FAIL program_enter: got pr=%b unl=%b exp 1 0", a_pr, a_unl);
    end
    new_code = 16'($urandom);
    if (new_code == A_PIN) new_code = new_code ^ 16'h0001;
    a_enter(new_code, early);
    m_code = new_code;
    n_tests++;
    if ({a_unl, a_pr, a_ok, a_bad} !== 4'b1000) begin
      n_fail++; $display("FAIL program_done: got unl=%b pr=%b ok=%b bad=%b exp 1 0 0 0", a_unl, a_pr, a_ok, a_bad);
    end
    a_relock_pulse();
    a_enter(A_PIN, early);
    n_tests++;
    if ({a_unl, a_bad, a_fc} !== 4'b0_1_01) begin
      n_fail++; $display("FAIL old_code_rejected: got unl=%b bad=%b fc=%0d exp 0 1 1", a_unl, a_bad, a_fc);
    end
    a_enter(m_code, early);
    n_tests++;
    if ({a_unl, a_ok, a_fc} !== 4'b1_1_00) begin
      n_fail++; $display("FAIL new_code_accepted %h: got unl=%b ok=%b fc=%0d exp 1 1 0", m_code, a_unl, a_ok, a_fc);
    end
    // Abort a programming session after two digits; the code must be unchanged.
    @(negedge clk); a_prog = 1;
    @(negedge clk); a_prog = 0; a_din = 4'h7; a_valid = 1;
    @(negedge clk); a_din = 4'h8;
    @(negedge clk); a_valid = 0; a_relock = 1;
    @(negedge clk); a_relock = 0;
    n_tests++;
    if ({a_pr, a_unl} !== 2'b00) begin
      n_fail++; $display("FAIL program_abort: got pr=%b unl=%b exp 0 0", a_pr, a_unl);
    end
    a_enter(m_code, early);
    n_tests++;
    if (a_unl !== 1'b1) begin
      n_fail++; $display("FAIL code_kept_after_abort: got unl=%b exp 1", a_unl);
    end
    do_reset();
    a_enter(A_PIN, early);
    n_tests++;
    if (a_unl !== 1'b1) begin
      n_fail++; $display("FAIL reset_restores_default: got unl=%b exp 1", a_unl);
    end
  endtask

  task automatic test_relock_priority();
    bit early;
    do_reset();
    a_enter(A_PIN, early);
    @(negedge clk); a_relock = 1; a_prog = 1;
    @(negedge clk); a_relock = 0; a_prog = 0;
    n_tests++;
    if ({a_unl, a_pr} !== 2'b00) begin
      n_fail++; $display("FAIL relock_wins: got unl=%b pr=%b exp 0 0", a_unl, a_pr);
    end
    @(negedge clk); a_din = 4'h3; a_valid = 1;
    @(negedge clk); a_din = 4'h9;
    @(negedge clk); a_valid = 0;
    do_reset();
    a_enter(A_PIN, early);
    n_tests++;
    if ({a_unl, a_ok} !== 2'b11) begin
      n_fail++; $display("FAIL reset_clears_partial: got unl=%b ok=%b exp 1 1", a_unl, a_ok);
    end
  endtask

  task automatic test_partial_persists();
    do_reset();
    @(negedge clk); a_din = 4'hC; a_valid = 1;
    @(negedge clk); a_din = 4'h0;
    @(negedge clk); a_valid = 0;
    repeat (10) @(negedge clk);
    n_tests++;
    if ({a_unl, a_bad} !== 2'b00) begin
      n_fail++; $display("FAIL partial_idle: got unl=%b bad=%b exp 0 0", a_unl, a_bad);
    end
    a_din = 4'hD; a_valid = 1;
    @(negedge clk); a_din = 4'hE;
    @(negedge clk); a_valid = 0;
    n_tests++;
    if ({a_unl, a_ok} !== 2'b11) begin
      n_fail++; $display("FAIL partial_resume: got unl=%b ok=%b exp 1 1", a_unl, a_ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq;
    do_reset();
    seq = {16'h1234, A_PIN};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_tests++;
        if ({a_bad, a_fc} !== 3'b1_01) begin
          n_fail++; $display("FAIL b2b_first_bad: got bad=%b fc=%0d exp 1 1", a_bad, a_fc);
        end
      end
      a_din   = seq[31-4*i -: 4];
      a_valid = 1;
    end
    @(negedge clk);
    a_valid = 0;
    n_tests++;
    if ({a_unl, a_ok, a_fc} !== 4'b1_1_00) begin
      n_fail++; $display("FAIL b2b_second_ok: got unl=%b ok=%b fc=%0d exp 1 1 0", a_unl, a_ok, a_fc);
    end
  endtask

  task automatic test_params_b();
    logic [47:0] wrong;
    int cyc;
    do_reset();
    wrong = 48'({$urandom, $urandom});
    if (wrong == B_PIN) wrong = wrong ^ 48'h1;
    b_enter(wrong);
    n_tests++;
    if ({b_bad, b_lo, b_fc, b_unl} !== 4'b1_1_1_0) begin
      n_fail++; $display("FAIL b_wrong_locks: got bad=%b lo=%b fc=%0d unl=%b exp 1 1 1 0", b_bad, b_lo, b_fc, b_unl);
    end
    b_wait_lockout(cyc);
    n_tests++;
    if (cyc !== 3) begin
      n_fail++; $display("FAIL b_lockout_duration: got %0d cycles exp 3", cyc);
    end
    n_tests++;
    if ({b_lo, b_fc} !== 2'b00) begin
      n_fail++; $display("FAIL b_lockout_exit: got lo=%b fc=%0d exp 0 0", b_lo, b_fc);
    end
    b_enter(B_PIN);
    n_tests++;
    if ({b_unl, b_ok, b_bad} !== 3'b110) begin
      n_fail++; $display("FAIL b_unlock: got unl=%b ok=%b bad=%b exp 1 1 0", b_unl, b_ok, b_bad);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_no_backdoor();
    test_lockout();
    test_random_attempts();
    test_program();
    test_relock_priority();
    test_partial_persists();
    test_back_to_back();
    test_params_b();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
